cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run-control unit wrapped around SingleCycleCPU. Gates CPU execution with a clock enable,
//  counts executed cycles and stops the CPU on halt instruction, cycle budget, user request or
//  PC breakpoint. Replaces fixed-delay simulation stop with a parametrised, synthesizable
//  controller. Reports the stop reason and the executed-cycle count.
// PARAMETERS
//  CYCLE_W     32          width of cycle counter
//  MAX_CYCLES  5000        cycle budget; 0 = no timeout
//  PC_W        32          CPU program-counter width
//  HALT_OP     6'b111111   opcode treated as halt
//  NUM_BP      2           breakpoint comparators (only with RUN_CTRL_BP_EN)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst_n        in   1                 asynchronous reset, active low
//  start        in   1                 pulse: clear counter, enter RUN
//  step         in   1                 pulse: execute one instruction from IDLE
//  stop_req     in   1                 user stop while running
//  cpu_pc       in   PC_W              PC of instruction executing this cycle
//  cpu_opcode   in   6                 opcode of that instruction
//  bp_we        in   1                 write breakpoint slot
//  bp_idx       in   $clog2(NUM_BP)    slot index
//  bp_addr      in   PC_W              breakpoint PC (bit0 of stored value = valid, set on write)
//  cpu_en       out  1                 CPU clock enable (PC/regfile/mem writes)
//  running      out  1                 state is RUN or STEP
//  done         out  1                 state is HALTED
//  halt_reason  out  3                 0 NONE,1 HALT_INSTR,2 BREAKPOINT,3 TIMEOUT,4 USER
//  cycle_count  out  CYCLE_W           instructions executed since last start
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, cpu_en=0, running=0, done=0, halt_reason=0,
//    cycle_count=0, breakpoint slots invalid. Applies mid-run immediately.
//  - States: IDLE, RUN, STEP, HALTED (2-bit register).
//  - IDLE: start -> RUN (count cleared, reason 0); step -> STEP; start+step same cycle: start wins.
//  - STEP: cpu_en=1 exactly one cycle, count+1, -> IDLE. Halt opcode in that cycle -> HALTED,
//    reason 1.
//  - RUN: cpu_en=1 each cycle unless breakpoint hit; count+1 per enabled cycle, saturating at
//    all-ones. Stop conditions sampled each cycle, priority HALT_INSTR > BREAKPOINT > TIMEOUT > USER:
//     HALT_INSTR: cpu_opcode==HALT_OP; instruction executes (cpu_en=1, counted), then HALTED.
//     BREAKPOINT: cpu_pc matches a valid slot; cpu_en forced 0 combinationally, not counted.
//     TIMEOUT: MAX_CYCLES!=0 and count+1==MAX_CYCLES on enabled cycle; that cycle executes.
//     USER: stop_req=1; cycle executes, then HALTED.
//  - Breakpoints ignored on first cycle after entering RUN or STEP (allows resume past bp).
//  - HALTED: cpu_en=0, done=1, reason held; only start leaves (-> RUN); step/stop_req ignored.
//  - stop_req in IDLE/HALTED ignored. start while RUN restarts: count cleared, stays RUN.
//  - Latency: start registered -> cpu_en high the following cycle; stop -> cpu_en low next cycle
//    (breakpoint: same cycle).
// CONFIGURATION
//  RUN_CTRL_BP_EN defined: NUM_BP slot registers, bp_we writes slot bp_idx, comparator on cpu_pc.
//  Undefined: bp_* ports present but ignored, no slot registers, reason 2 never produced.
// STRUCTURE
//  Shared package cpu_run_pkg: state encoding (IDLE/RUN/STEP/HALTED), halt_reason constants,
//  HALT_OP default. Sub-module cpu_bp_match (slot regs + parallel compare, hit out) under
//  RUN_CTRL_BP_EN; FSM and counter in cpu_run_ctrl.
// TESTING
//  1. start; halt opcode at cycle 10 -> cpu_en high 10 cycles, cycle_count=10, done=1, reason=1.
//  2. MAX_CYCLES=20, no halt -> cycle_count=20, reason=3, cpu_en low from next cycle.
//  3. step x3 from IDLE -> three single cpu_en pulses, count=3, state IDLE; start clears to 0.
//  4. bp slot0=0x0000_0040; run to pc 0x40 -> cpu_en 0 that cycle, reason=2; start resumes past.
//  5. stop_req and halt opcode same cycle -> reason=1; stop_req alone at count 7 -> reason=4.
//  6. rst_n low mid-RUN -> all outputs reset asynchronously; start+step together -> RUN.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run-control block: FSM state encoding, stop-reason codes,
// default halt opcode and a helper for index widths.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        RSN_NONE       = 3'd0,
        RSN_HALT_INSTR = 3'd1,
        RSN_BREAKPOINT = 3'd2,
        RSN_TIMEOUT    = 3'd3,
        RSN_USER       = 3'd4
    } halt_reason_t;

    localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

    // A single slot still needs a 1-bit index port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_bp_match.sv
// Breakpoint slot registers with a parallel PC comparator; hit is combinational on cpu_pc.
// Stored bit0 is the slot-valid flag, so PCs are matched on bits [PC_W-1:1].
module cpu_bp_match
    import cpu_run_pkg::*;
#(
    parameter  int unsigned PC_W     = 32,
    parameter  int unsigned NUM_BP   = 2,
    localparam int unsigned BP_IDX_W = idx_w(NUM_BP)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_bp_we,
    input  logic [BP_IDX_W-1:0] i_bp_idx,
    input  logic [PC_W-1:0]     i_bp_addr,
    input  logic [PC_W-1:0]     i_cpu_pc,
    output logic                o_hit
);

    logic [PC_W-1:0] r_slot [NUM_BP];
    logic            w_unused_lsb;

    assign w_unused_lsb = i_bp_addr[0] ^ i_cpu_pc[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BP; i++) begin
                r_slot[i] <= '0;
            end
        end else if (i_bp_we) begin
            r_slot[i_bp_idx] <= {i_bp_addr[PC_W-1:1], 1'b1};
        end
    end

    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (r_slot[i][0] && (r_slot[i][PC_W-1:1] == i_cpu_pc[PC_W-1:1])) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control FSM and executed-cycle counter gating a single-cycle CPU via cpu_en.
// Breakpoint comparators are built only when RUN_CTRL_BP_EN is defined.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter  int unsigned CYCLE_W    = 32,
    parameter  int unsigned MAX_CYCLES = 5000,
    parameter  int unsigned PC_W       = 32,
    parameter  logic [5:0]  HALT_OP    = HALT_OP_DEFAULT,
    parameter  int unsigned NUM_BP     = 2,
    localparam int unsigned BP_IDX_W   = idx_w(NUM_BP)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                step,
    input  logic                stop_req,
    input  logic [PC_W-1:0]     cpu_pc,
    input  logic [5:0]          cpu_opcode,
    input  logic                bp_we,
    input  logic [BP_IDX_W-1:0] bp_idx,
    input  logic [PC_W-1:0]     bp_addr,
    output logic                cpu_en,
    output logic                running,
    output logic                done,
    output logic [2:0]          halt_reason,
    output logic [CYCLE_W-1:0]  cycle_count
);

    localparam logic [CYCLE_W-1:0] MAX_C = CYCLE_W'(MAX_CYCLES);

    run_state_t         r_state;
    halt_reason_t       r_reason;
    logic [CYCLE_W-1:0] r_count;
    logic               r_first;

    logic               w_bp_hit;
    logic               w_bp_eff;
    logic               w_halt;
    logic               w_timeout;
    logic [CYCLE_W-1:0] w_cnt_inc;
    logic [CYCLE_W-1:0] w_cnt_sat;

`ifdef RUN_CTRL_BP_EN
    cpu_bp_match #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bp_we   (bp_we),
        .i_bp_idx  (bp_idx),
        .i_bp_addr (bp_addr),
        .i_cpu_pc  (cpu_pc),
        .o_hit     (w_bp_hit)
    );
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{bp_we, bp_idx, bp_addr, cpu_pc};
    assign w_bp_hit    = 1'b0;
`endif

    // The first cycle after entering RUN/STEP ignores breakpoints so a resume can step past one.
    assign w_bp_eff  = w_bp_hit && !r_first;
    assign w_halt    = (cpu_opcode == HALT_OP);
    assign w_cnt_inc = r_count + CYCLE_W'(1);
    assign w_cnt_sat = (&r_count) ? r_count : w_cnt_inc;
    assign w_timeout = (MAX_CYCLES != 0) && (w_cnt_sat == MAX_C);

    // A halt instruction outranks a breakpoint, so it still executes on a matching PC.
    assign cpu_en      = ((r_state == ST_RUN) && !(w_bp_eff && !w_halt)) || (r_state == ST_STEP);
    assign running     = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign done        = (r_state == ST_HALTED);
    assign halt_reason = r_reason;
    assign cycle_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_reason <= RSN_NONE;
            r_count  <= '0;
            r_first  <= 1'b0;
        end else begin
            r_first <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_count  <= '0;
                        r_reason <= RSN_NONE;
                        r_first  <= 1'b1;
                    end else if (step) begin
                        r_state <= ST_STEP;
                        r_first <= 1'b1;
                    end
                end
                ST_STEP: begin
                    r_count <= w_cnt_sat;
                    if (w_halt) begin
                        r_state  <= ST_HALTED;
                        r_reason <= RSN_HALT_INSTR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        r_count  <= '0;
                        r_reason <= RSN_NONE;
                        r_first  <= 1'b1;
                    end else if (w_halt) begin
                        r_count  <= w_cnt_sat;
                        r_state  <= ST_HALTED;
                        r_reason <= RSN_HALT_INSTR;
                    end else if (w_bp_eff) begin
                        r_state  <= ST_HALTED;
                        r_reason <= RSN_BREAKPOINT;
                    end else begin
                        r_count <= w_cnt_sat;
                        if (w_timeout) begin
                            r_state  <= ST_HALTED;
                            r_reason <= RSN_TIMEOUT;
                        end else if (stop_req) begin
                            r_state  <= ST_HALTED;
                            r_reason <= RSN_USER;
                        end
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_count  <= '0;
                        r_reason <= RSN_NONE;
                        r_first  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: each run-ending event (running falling) is matched against
// a queued expectation of reason, count, done and number of cpu_en cycles observed.
module tb_cpu_run_ctrl;

    localparam logic [31:0] NO_HALT = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        stop_req = 1'b0;
    logic        bp_we = 1'b0;
    logic [0:0]  bp_idx = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] cpu_pc;
    logic [5:0]  cpu_opcode;
    logic        cpu_en;
    logic        running;
    logic        done;
    logic [2:0]  halt_reason;
    logic [31:0] cycle_count;

    logic [31:0] r_pc = 32'h0;
    logic        pc_clr = 1'b0;
    logic [31:0] halt_pc = NO_HALT;

    cpu_run_ctrl #(
        .CYCLE_W    (32),
        .MAX_CYCLES (20),
        .PC_W       (32),
        .HALT_OP    (6'b111111),
        .NUM_BP     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .step        (step),
        .stop_req    (stop_req),
        .cpu_pc      (cpu_pc),
        .cpu_opcode  (cpu_opcode),
        .bp_we       (bp_we),
        .bp_idx      (bp_idx),
        .bp_addr     (bp_addr),
        .cpu_en      (cpu_en),
        .running     (running),
        .done        (done),
        .halt_reason (halt_reason),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Minimal CPU stand-in: PC advances by one word per enabled cycle.
    always @(posedge clk) begin
        if (pc_clr)      r_pc <= 32'h0;
        else if (cpu_en) r_pc <= r_pc + 32'd4;
    end
    assign cpu_pc     = r_pc;
    assign cpu_opcode = (r_pc == halt_pc) ? 6'h3F : 6'h01;

    typedef struct {
        string       name;
        logic [2:0]  reason;
        logic [31:0] count;
        logic        done;
        int          en;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   en_cnt = 0;
    logic prev_run = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (cpu_en) en_cnt++;
        if (!rst_n) en_cnt = 0;
        if (prev_run && !running) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_stop: reason=%0d count=%0d done=%0b with no expectation queued",
                         halt_reason, cycle_count, done);
            end else begin
                e = sb.pop_front();
                if (halt_reason == e.reason && cycle_count == e.count && done == e.done &&
                    cpu_en == 1'b0 && en_cnt == e.en) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got reason=%0d count=%0d done=%0b cpu_en=%0b en_cycles=%0d, expected reason=%0d count=%0d done=%0b cpu_en=0 en_cycles=%0d",
                             e.name, halt_reason, cycle_count, done, cpu_en, en_cnt,
                             e.reason, e.count, e.done, e.en);
                end
            end
        end
        if (start) en_cnt = 0;
        prev_run = running;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic expect_stop(input string nm, input logic [2:0] r, input int c,
                               input logic d, input int en);
        exp_t e;
        e.name = nm; e.reason = r; e.count = c; e.done = d; e.en = en;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; tick(); step = 1'b0;
    endtask

    task automatic clr_pc();
        pc_clr = 1'b1; tick(); pc_clr = 1'b0;
    endtask

    task automatic wait_stop(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!running) begin
                tick();
                return;
            end
            tick();
        end
        n_chk++;
        $display("FAIL %s: still running after %0d cycles, expected stop", nm, budget);
    endtask

    task automatic wait_count(input string nm, input int v, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cycle_count == v) return;
            tick();
        end
        n_chk++;
        $display("FAIL %s: cycle_count=%0d never reached %0d", nm, cycle_count, v);
    endtask

    task automatic user_stop();
        stop_req = 1'b1; tick(); stop_req = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset_state", {cpu_en, running, done, halt_reason, cycle_count}, 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        halt_pc = 32'd36;
        clr_pc();
        expect_stop("halt_at_10", 3'd1, 10, 1'b1, 10);
        pulse_start();
        wait_stop("halt_at_10", 100);

        halt_pc = NO_HALT;
        clr_pc();
        expect_stop("timeout_20", 3'd3, 20, 1'b1, 20);
        pulse_start();
        wait_stop("timeout_20", 100);

        bp_we = 1'b1; bp_idx = 1'b0; bp_addr = 32'h0000_0040;
        tick();
        bp_we = 1'b0;
        clr_pc();
`ifdef RUN_CTRL_BP_EN
        expect_stop("bp_hit", 3'd2, 16, 1'b1, 16);
`else
        expect_stop("bp_hit", 3'd3, 20, 1'b1, 20);
`endif
        pulse_start();
        wait_stop("bp_hit", 100);
        expect_stop("bp_resume", 3'd3, 20, 1'b1, 20);
        pulse_start();
        wait_stop("bp_resume", 100);

        halt_pc = 32'd20;
        clr_pc();
        expect_stop("halt_beats_user", 3'd1, 6, 1'b1, 6);
        pulse_start();
        wait_count("halt_beats_user", 5, 50);
        user_stop();
        wait_stop("halt_beats_user", 100);
        halt_pc = NO_HALT;

        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        clr_pc();
        for (int k = 1; k <= 3; k++) begin
            expect_stop($sformatf("step_%0d", k), 3'd0, k, 1'b0, k);
            pulse_step();
            wait_stop("step", 20);
        end

        expect_stop("user_stop_7", 3'd4, 7, 1'b1, 7);
        pulse_start();
        chk("start_clears_count", cycle_count, 64'h0);
        wait_count("user_stop_7", 6, 50);
        user_stop();
        wait_stop("user_stop_7", 100);

        clr_pc();
        pulse_start();
        repeat (5) tick();
        expect_stop("reset_mid_run", 3'd0, 0, 1'b0, 0);
        rst_n = 1'b0;
        #2;
        chk("async_reset", {cpu_en, running, done, halt_reason, cycle_count}, 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        clr_pc();
        expect_stop("start_wins_over_step", 3'd4, 3, 1'b1, 3);
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        wait_count("start_wins_over_step", 2, 50);
        user_stop();
        wait_stop("start_wins_over_step", 100);

        tick();
        chk("scoreboard_drained", sb.size(), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
